// File: rtl/shift_operand_stage_if.sv
// Handshake and operand bus for the shift operand stage.
// master: upstream decode / EX side that drives instructions and consumes results.
// slave:  the shift operand stage itself.
interface shift_operand_stage_if #(
    parameter int DW = 32,
    parameter int SW = 5
);
    // Upstream instruction handshake
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [SW-1:0] in_shamt;
    logic [4:0]    in_rs_addr;
    logic [DW-1:0] in_rs_data;
    logic [4:0]    in_rt_addr;
    logic [DW-1:0] in_rt_data;
    logic [4:0]    in_rd;
    logic          flush;

    // Forwarding sources
    logic          exmem_wr;
    logic [4:0]    exmem_rd;
    logic [DW-1:0] exmem_data;
    logic          memwb_wr;
    logic [4:0]    memwb_rd;
    logic [DW-1:0] memwb_data;

    // Downstream (EX shifter) handshake
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_input;
    logic [SW-1:0] out_index;
    logic          out_direction;
    logic [DW-1:0] out_mask;
    logic [4:0]    out_rd;
    logic          out_illegal;

    modport master (
        output in_valid, in_op, in_shamt, in_rs_addr, in_rs_data,
               in_rt_addr, in_rt_data, in_rd, flush,
               exmem_wr, exmem_rd, exmem_data,
               memwb_wr, memwb_rd, memwb_data,
               out_ready,
        input  in_ready, out_valid, out_input, out_index, out_direction,
               out_mask, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_shamt, in_rs_addr, in_rs_data,
               in_rt_addr, in_rt_data, in_rd, flush,
               exmem_wr, exmem_rd, exmem_data,
               memwb_wr, memwb_rd, memwb_data,
               out_ready,
        output in_ready, out_valid, out_input, out_index, out_direction,
               out_mask, out_rd, out_illegal
    );
endinterface

// File: rtl/shift_operand_stage.sv
// Shift operand stage: resolves operands of MIPS shift instructions, derives
// shift index / direction / logical-right correction mask, and queues the
// result in a 2-entry FIFO skid buffer feeding the EX barrel shifter.
// The EX stage forms its result as shifter_out & out_mask, so srl/srlv are
// built from a left/arithmetic-right shifter plus a mask of the vacated bits.
// Optional feature macro: SHIFT_FWD_EN (EX/MEM and MEM/WB operand forwarding).
// Only DW=32 / SW=5 is supported.
module shift_operand_stage #(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input logic                clk,
    input logic                rstn,
    shift_operand_stage_if.slave bus
);

    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_SLLV = 3'd3;
    localparam logic [2:0] OP_SRLV = 3'd4;
    localparam logic [2:0] OP_SRAV = 3'd5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] index;
        logic          direction;
        logic [DW-1:0] mask;
        logic [4:0]    rd;
        logic          illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        data:      '0,
        index:     '0,
        direction: 1'b0,
        mask:      {DW{1'b1}},
        rd:        '0,
        illegal:   1'b0
    };

    logic [1:0]    count;
    entry_t        head_q;
    entry_t        tail_q;
    entry_t        new_entry;
    logic [DW-1:0] rs_res;
    logic [DW-1:0] rt_res;
    logic          push;
    logic          pop;

`ifdef SHIFT_FWD_EN
    // Register 0 is hardwired; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [DW-1:0] resolve(
        input logic [4:0]    addr,
        input logic [DW-1:0] rf_data,
        input logic          ex_wr,
        input logic [4:0]    ex_rd,
        input logic [DW-1:0] ex_data,
        input logic          wb_wr,
        input logic [4:0]    wb_rd,
        input logic [DW-1:0] wb_data
    );
        logic [DW-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (ex_wr && (ex_rd == addr)) begin
            val = ex_data;
        end else if (wb_wr && (wb_rd == addr)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign rs_res = resolve(bus.in_rs_addr, bus.in_rs_data,
                            bus.exmem_wr, bus.exmem_rd, bus.exmem_data,
                            bus.memwb_wr, bus.memwb_rd, bus.memwb_data);
    assign rt_res = resolve(bus.in_rt_addr, bus.in_rt_data,
                            bus.exmem_wr, bus.exmem_rd, bus.exmem_data,
                            bus.memwb_wr, bus.memwb_rd, bus.memwb_data);
`else
    // Without forwarding, operands come straight from the register file.
    function automatic logic [DW-1:0] resolve(
        input logic [4:0]    addr,
        input logic [DW-1:0] rf_data
    );
        return (addr == 5'd0) ? '0 : rf_data;
    endfunction

    assign rs_res = resolve(bus.in_rs_addr, bus.in_rs_data);
    assign rt_res = resolve(bus.in_rt_addr, bus.in_rt_data);

    // Forwarding inputs are intentionally ignored in this build.
    logic unused_fwd;
    assign unused_fwd = ^{bus.exmem_wr, bus.exmem_rd, bus.exmem_data,
                          bus.memwb_wr, bus.memwb_rd, bus.memwb_data};
`endif

    // Variable shifts only look at the low SW bits of rs.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_res[DW-1:SW];

    // Decode the incoming instruction into the entry the shifter will consume.
    always_comb begin
        new_entry           = RESET_ENTRY;
        new_entry.data      = rt_res;
        new_entry.rd        = bus.in_rd;
        case (bus.in_op)
            OP_SLL: begin
                new_entry.index     = bus.in_shamt;
                new_entry.direction = 1'b0;
            end
            OP_SRL: begin
                new_entry.index     = bus.in_shamt;
                new_entry.direction = 1'b1;
                new_entry.mask      = {DW{1'b1}} >> bus.in_shamt;
            end
            OP_SRA: begin
                new_entry.index     = bus.in_shamt;
                new_entry.direction = 1'b1;
            end
            OP_SLLV: begin
                new_entry.index     = rs_res[SW-1:0];
                new_entry.direction = 1'b0;
            end
            OP_SRLV: begin
                new_entry.index     = rs_res[SW-1:0];
                new_entry.direction = 1'b1;
                new_entry.mask      = {DW{1'b1}} >> rs_res[SW-1:0];
            end
            OP_SRAV: begin
                new_entry.index     = rs_res[SW-1:0];
                new_entry.direction = 1'b1;
            end
            default: begin
                // Illegal ops still flow down the pipe so EX can raise the trap;
                // the shifter sees a harmless zero-distance left shift of rt.
                new_entry.illegal   = 1'b1;
            end
        endcase
    end

    // Handshake decode, all derived from the registered occupancy count.
    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Two-entry FIFO: head_q always drives the outputs, tail_q is the skid slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= 2'd0;
            head_q <= RESET_ENTRY;
            tail_q <= RESET_ENTRY;
        end else if (bus.flush) begin
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= new_entry;
                    end else begin
                        tail_q <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Push is only possible below full, and pop needs an entry,
                    // so count is 1 here: the new entry replaces the head.
                    head_q <= new_entry;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_input     = head_q.data;
    assign bus.out_index     = head_q.index;
    assign bus.out_direction = head_q.direction;
    assign bus.out_mask      = head_q.mask;
    assign bus.out_rd        = head_q.rd;
    assign bus.out_illegal   = head_q.illegal;

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Pipeline stage directly upstream of the EX-stage barrel shifter (left shift / arithmetic right shift only).
- Accepts decoded MIPS shift instructions (sll, srl, sra, sllv, srlv, srav) and resolves operands, with EX/MEM and MEM/WB forwarding when the forwarding feature is compiled in.
- Computes the shift index, direction and a logical-right correction mask, then holds them in a 2-entry skid buffer with valid/ready handshake.
- The EX stage forms the result as shifter_out AND out_mask.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- SW, 5, shift-amount width, log2(DW).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept an instruction
- in_op  in  3  0=sll 1=srl 2=sra 3=sllv 4=srlv 5=srav; 6,7 illegal
- in_shamt  in  5  instruction shamt field
- in_rs_addr  in  5  rs register number
- in_rs_data  in  32  register-file rs value
- in_rt_addr  in  5  rt register number
- in_rt_data  in  32  register-file rt value
- in_rd  in  5  destination register
- flush  in  1  synchronous discard of all buffered entries
- exmem_wr  in  1  EX/MEM stage writes a register
- exmem_rd  in  5  EX/MEM destination
- exmem_data  in  32  EX/MEM result
- memwb_wr  in  1  MEM/WB stage writes a register
- memwb_rd  in  5  MEM/WB destination
- memwb_data  in  32  MEM/WB result
- out_valid  out  1  head entry valid
- out_ready  in  1  EX stage consumes head entry
- out_input  out  32  shifter data input (resolved rt)
- out_index  out  5  shift amount
- out_direction  out  1  0=left, 1=right
- out_mask  out  32  AND mask applied to shifter output
- out_rd  out  5  destination register
- out_illegal  out  1  head entry carries an illegal op

Behaviour:
- Reset (rstn low, asynchronous): buffer count=0, out_valid=0, in_ready=1. out_input, out_index, out_direction, out_rd and out_illegal are 0; out_mask is 32'hFFFFFFFF.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready. Buffer is FIFO with 2 entries.
- in_ready = (count < 2), driven from registered count. A full buffer never accepts.
- Latency: a push in cycle N makes the entry visible at the outputs in cycle N+1 if the buffer was empty. Outputs are always driven from registered head-entry state; there is no combinational in-to-out path.
- Simultaneous push and pop with count=1: count stays 1, and the new entry becomes head in the next cycle.
- count=2 with a pop: in_ready rises in the next cycle.
- Outputs hold stable while out_valid & !out_ready.
- Flush has priority over push and pop. In the next cycle count=0 and out_valid=0. A push presented in the flush cycle is dropped.
- Operand resolution, sampled only at push, for each of rs and rt:
  - register 0 always yields 0;
  - else if exmem_wr & exmem_rd==addr, take exmem_data;
  - else if memwb_wr & memwb_rd==addr, take memwb_data;
  - else take the register-file value.
- Index: sll/srl/sra use in_shamt; sllv/srlv/srav use resolved_rs[4:0]. Upper rs bits are ignored.
- Direction: 0 for sll and sllv, 1 for all other legal ops.
- Mask: srl/srlv use 32'hFFFFFFFF >> index (logical shift), so index 0 gives all ones and index 31 gives 32'h00000001. All other ops use all ones.
- Illegal op (6, 7): the entry is accepted and marked out_illegal=1, with index=0, direction=0, mask all ones, and out_input = resolved rt.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: SHIFT_FWD_EN.
- Defined: forwarding as described in Behaviour.
- Undefined: the exmem_* and memwb_* inputs are ignored. Operands come only from the register-file values, with register 0 still forced to 0.

Test Plan:
- Reset, then push srl rt=32'h80000000 shamt=4 with out_ready=1 -> next cycle out_valid=1, out_input=32'h80000000, out_index=4, out_direction=1, out_mask=32'h0FFFFFFF.
- srav with rs=32'hFFFFFFE3, rt=32'hF0000000 -> out_index=3, out_direction=1, out_mask=32'hFFFFFFFF.
- sllv with rs=5 while exmem_wr=1, exmem_rd=5, exmem_data=7, memwb_wr=1, memwb_rd=5, memwb_data=9 -> out_index=7. The same push with rs_addr=0 -> out_index=0. With SHIFT_FWD_EN undefined -> index from in_rs_data.
- Hold out_ready=0 and push 3 back-to-back instructions -> only 2 accepted and in_ready=0 after the second. Release out_ready -> entries pop in order, and in_ready=1 the cycle after the first pop.
- count=2, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed-cycle push never appears.
- in_op=6 -> out_illegal=1, out_index=0, out_mask=32'hFFFFFFFF. Drop rstn asynchronously mid-stream -> out_valid falls without a clock edge.
